uart_rx_frame_ctrl: RTL and testbench

UART_RX_FRAME_CTRL -- requirements
Module: uart_rx_frame_ctrl

---
 rtl/uart_frame_pkg.sv | 23 ++
 rtl/frame_timeout.sv | 31 +++
 rtl/uart_rx_frame_ctrl.sv | 147 ++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
// Shared types and defaults for the UART receive frame controller.
// Holds the FSM state encoding, error-code constants and parameter defaults.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_LEN,
        S_GET_PAY,
        S_GET_CHK,
        S_OK,
        S_ERR
    } state_e;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_LEN  = 2'b01;
    localparam logic [1:0] ERR_CHK  = 2'b10;
    localparam logic [1:0] ERR_TO   = 2'b11;

    localparam logic [7:0]  DEF_HEADER   = 8'hA5;
    localparam int unsigned DEF_MAX_LEN  = 8;
    localparam int unsigned DEF_TO_TICKS = 16;

endpackage

// File: rtl/frame_timeout.sv
// Inter-byte timeout: counts tick_i pulses while enabled.
// Ports: clk_i, rst_i, clear_i, enable_i, tick_i in; expired_o out.
module frame_timeout #(
    parameter int unsigned TO_TICKS = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    input  logic tick_i,
    output logic expired_o
);

    logic [7:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (clear_i || !enable_i) begin
            cnt_q <= '0;
        end else if (tick_i) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    // Fires on the tick that would make the count reach TO_TICKS, so the
    // FSM leaves on that same edge; a coincident clear suppresses it.
    assign expired_o = enable_i && !clear_i && tick_i &&
                       (cnt_q == 8'(TO_TICKS - 1));

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Frame parser: HEADER, LEN, LEN payload bytes, CHK (XOR of LEN+payload).
// Ports: clk_i, rst_i, rx_data_i/rx_valid_i, tick_i in; frame_we_o,
// frame_addr_o, frame_data_o, len_o, frame_ok_o, frame_err_o,
// err_code_o, busy_o out (all registered).
module uart_rx_frame_ctrl
    import uart_frame_pkg::*;
#(
    parameter logic [7:0]  HEADER   = DEF_HEADER,
    parameter int unsigned MAX_LEN  = DEF_MAX_LEN,
    parameter int unsigned TO_TICKS = DEF_TO_TICKS
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i,
    input  logic       tick_i,
    output logic       frame_we_o,
    output logic [3:0] frame_addr_o,
    output logic [7:0] frame_data_o,
    output logic [3:0] len_o,
    output logic       frame_ok_o,
    output logic       frame_err_o,
    output logic [1:0] err_code_o,
    output logic       busy_o
);

    state_e     state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic [7:0] chk_q, chk_d;
    logic [3:0] len_d;
    logic       we_d;
    logic [3:0] addr_d;
    logic [7:0] data_d;
    logic [1:0] code_d;
    logic       waiting;
    logic       expired;

    assign waiting = (state_q == S_GET_LEN) ||
                     (state_q == S_GET_PAY) ||
                     (state_q == S_GET_CHK);

    frame_timeout #(
        .TO_TICKS (TO_TICKS)
    ) u_timeout (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (rx_valid_i),
        .enable_i  (waiting),
        .tick_i    (tick_i),
        .expired_o (expired)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        chk_d   = chk_q;
        len_d   = len_o;
        we_d    = 1'b0;
        addr_d  = frame_addr_o;
        data_d  = frame_data_o;
        code_d  = err_code_o;
        unique case (state_q)
            S_IDLE: begin
                if (rx_valid_i && rx_data_i == HEADER) begin
                    state_d = S_GET_LEN;
                end
            end
            S_GET_LEN: begin
                if (rx_valid_i) begin
                    if (rx_data_i == 8'd0 || rx_data_i > 8'(MAX_LEN)) begin
                        state_d = S_ERR;
                        code_d  = ERR_LEN;
                    end else begin
                        len_d   = rx_data_i[3:0];
                        chk_d   = rx_data_i;
                        idx_d   = '0;
                        state_d = S_GET_PAY;
                    end
                end else if (expired) begin
                    state_d = S_ERR;
                    code_d  = ERR_TO;
                end
            end
            S_GET_PAY: begin
                if (rx_valid_i) begin
                    we_d   = 1'b1;
                    addr_d = idx_q;
                    data_d = rx_data_i;
                    chk_d  = chk_q ^ rx_data_i;
                    idx_d  = idx_q + 4'd1;
                    if (idx_q == len_o - 4'd1) begin
                        state_d = S_GET_CHK;
                    end
                end else if (expired) begin
                    state_d = S_ERR;
                    code_d  = ERR_TO;
                end
            end
            S_GET_CHK: begin
                if (rx_valid_i) begin
                    if (rx_data_i == chk_q) begin
                        state_d = S_OK;
                        code_d  = ERR_NONE;
                    end else begin
                        state_d = S_ERR;
                        code_d  = ERR_CHK;
                    end
                end else if (expired) begin
                    state_d = S_ERR;
                    code_d  = ERR_TO;
                end
            end
            S_OK:    state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            chk_q        <= '0;
            len_o        <= '0;
            frame_we_o   <= 1'b0;
            frame_addr_o <= '0;
            frame_data_o <= '0;
            frame_ok_o   <= 1'b0;
            frame_err_o  <= 1'b0;
            err_code_o   <= ERR_NONE;
            busy_o       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            chk_q        <= chk_d;
            len_o        <= len_d;
            frame_we_o   <= we_d;
            frame_addr_o <= addr_d;
            frame_data_o <= data_d;
            frame_ok_o   <= (state_d == S_OK);
            frame_err_o  <= (state_d == S_ERR);
            err_code_o   <= code_d;
            busy_o       <= (state_d != S_IDLE);
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Testbench for uart_rx_frame_ctrl: per-cycle vector table plus a
// hand-written mid-frame reset sequence.
module tb_uart_rx_frame_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [7:0] rx_data_i = '0;
    logic       rx_valid_i = 1'b0;
    logic       tick_i = 1'b0;
    logic       frame_we_o;
    logic [3:0] frame_addr_o;
    logic [7:0] frame_data_o;
    logic [3:0] len_o;
    logic       frame_ok_o;
    logic       frame_err_o;
    logic [1:0] err_code_o;
    logic       busy_o;

    uart_rx_frame_ctrl dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .rx_data_i    (rx_data_i),
        .rx_valid_i   (rx_valid_i),
        .tick_i       (tick_i),
        .frame_we_o   (frame_we_o),
        .frame_addr_o (frame_addr_o),
        .frame_data_o (frame_data_o),
        .len_o        (len_o),
        .frame_ok_o   (frame_ok_o),
        .frame_err_o  (frame_err_o),
        .err_code_o   (err_code_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string      n;
        logic       v;
        logic [7:0] d;
        logic       t;
        logic       we;
        logic [3:0] a;
        logic [7:0] wd;
        logic       ok;
        logic       er;
        logic [1:0] code;
        logic [3:0] len;
        logic       busy;
    } vec_t;

    vec_t vq[$];
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic void add(string n, logic v, logic [7:0] d,
                                logic t, logic we, logic [3:0] a,
                                logic [7:0] wd, logic ok, logic er,
                                logic [1:0] code, logic [3:0] len,
                                logic busy);
        vec_t e;
        e.n = n; e.v = v; e.d = d; e.t = t;
        e.we = we; e.a = a; e.wd = wd;
        e.ok = ok; e.er = er; e.code = code;
        e.len = len; e.busy = busy;
        vq.push_back(e);
    endfunction

    task automatic check(string n, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", n, act, exp);
    endtask

    task automatic apply_vecs();
        foreach (vq[i]) begin
            @(negedge clk_i);
            rx_valid_i = vq[i].v;
            rx_data_i  = vq[i].d;
            tick_i     = vq[i].t;
            @(posedge clk_i);
            #1;
            check({vq[i].n, " ctl"},
                  32'({frame_we_o, frame_ok_o, frame_err_o,
                       err_code_o, len_o, busy_o}),
                  32'({vq[i].we, vq[i].ok, vq[i].er,
                       vq[i].code, vq[i].len, vq[i].busy}));
            if (vq[i].we)
                check({vq[i].n, " wr"},
                      32'({frame_addr_o, frame_data_o}),
                      32'({vq[i].a, vq[i].wd}));
        end
        @(negedge clk_i);
        rx_valid_i = 1'b0;
        rx_data_i  = '0;
        tick_i     = 1'b0;
        vq.delete();
    endtask

    function automatic logic [31:0] all_out();
        return 32'({frame_we_o, frame_addr_o, frame_data_o, len_o,
                    frame_ok_o, frame_err_o, err_code_o, busy_o});
    endfunction

    initial begin
        #1;
        check("reset state", all_out(), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // good frame; checksum 03^11^22^33 = 03
        add("f1 hdr",  1, 8'hA5, 0, 0, 0, 8'h00, 0, 0, 2'd0, 4'd0, 1);
        add("f1 len",  1, 8'h03, 0, 0, 0, 8'h00, 0, 0, 2'd0, 4'd3, 1);
        add("f1 p0",   1, 8'h11, 0, 1, 0, 8'h11, 0, 0, 2'd0, 4'd3, 1);
        add("f1 p1",   1, 8'h22, 0, 1, 1, 8'h22, 0, 0, 2'd0, 4'd3, 1);
        add("f1 p2",   1, 8'h33, 0, 1, 2, 8'h33, 0, 0, 2'd0, 4'd3, 1);
        add("f1 chk",  1, 8'h03, 0, 0, 0, 8'h00, 1, 0, 2'd0, 4'd3, 1);
        add("f1 drop", 1, 8'hA5, 0, 0, 0, 8'h00, 0, 0, 2'd0, 4'd3, 0);
        add("f1 idle", 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 2'd0, 4'd3, 0);
        // checksum mismatch
        add("f2 hdr",  1, 8'hA5, 0, 0, 0, 8'h00, 0, 0, 2'd0, 4'd3, 1);
        add("f2 len",  1, 8'h03, 0, 0, 0, 8'h00, 0, 0, 2'd0, 4'd3, 1);
        add("f2 p0",   1, 8'h11, 0, 1, 0, 8'h11, 0, 0, 2'd0, 4'd3, 1);
        add("f2 p1",   1, 8'h22, 0, 1, 1, 8'h22, 0, 0, 2'd0, 4'd3, 1);
        add("f2 p2",   1, 8'h33, 0, 1, 2, 8'h33, 0, 0, 2'd0, 4'd3, 1);
        add("f2 chk",  1, 8'h01, 0, 0, 0, 8'h00, 0, 1, 2'd2, 4'd3, 1);
        add("f2 idle", 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 2'd2, 4'd3, 0);
        // length errors: 0 and MAX_LEN+1
        add("l0 hdr",  1, 8'hA5, 0, 0, 0, 8'h00, 0, 0, 2'd2, 4'd3, 1);
        add("l0 len",  1, 8'h00, 0, 0, 0, 8'h00, 0, 1, 2'd1, 4'd3, 1);
        add("l0 idle", 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 2'd1, 4'd3, 0);
        add("l9 hdr",  1, 8'hA5, 0, 0, 0, 8'h00, 0, 0, 2'd1, 4'd3, 1);
        add("l9 len",  1, 8'h09, 0, 0, 0, 8'h00, 0, 1, 2'd1, 4'd3, 1);
        add("l9 idle", 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 2'd1, 4'd3, 0);
        // timeout after one payload byte
        add("to hdr",  1, 8'hA5, 0, 0, 0, 8'h00, 0, 0, 2'd1, 4'd3, 1);
        add("to len",  1, 8'h02, 0, 0, 0, 8'h00, 0, 0, 2'd1, 4'd2, 1);
        add("to p0",   1, 8'h10, 0, 1, 0, 8'h10, 0, 0, 2'd1, 4'd2, 1);
        for (int k = 1; k < 16; k++)
            add($sformatf("to tick%0d", k),
                0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 2'd1, 4'd2, 1);
        add("to tick16", 0, 8'h00, 1, 0, 0, 8'h00, 0, 1, 2'd3, 4'd2, 1);
        add("to idle",   0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 2'd3, 4'd2, 0);
        add("r1 hdr",  1, 8'hA5, 0, 0, 0, 8'h00, 0, 0, 2'd3, 4'd2, 1);
        add("r1 len",  1, 8'h01, 0, 0, 0, 8'h00, 0, 0, 2'd3, 4'd1, 1);
        add("r1 p0",   1, 8'h7E, 0, 1, 0, 8'h7E, 0, 0, 2'd3, 4'd1, 1);
        add("r1 chk",  1, 8'h7F, 0, 0, 0, 8'h00, 1, 0, 2'd0, 4'd1, 1);
        add("r1 idle", 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 2'd0, 4'd1, 0);
        // byte coincident with the 16th tick; checksum 02^55^66 = 31
        add("co hdr",  1, 8'hA5, 0, 0, 0, 8'h00, 0, 0, 2'd0, 4'd1, 1);
        add("co len",  1, 8'h02, 0, 0, 0, 8'h00, 0, 0, 2'd0, 4'd2, 1);
        for (int k = 1; k < 16; k++)
            add($sformatf("co tick%0d", k),
                0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 2'd0, 4'd2, 1);
        add("co p0",   1, 8'h55, 1, 1, 0, 8'h55, 0, 0, 2'd0, 4'd2, 1);
        add("co p1",   1, 8'h66, 0, 1, 1, 8'h66, 0, 0, 2'd0, 4'd2, 1);
        add("co chk",  1, 8'h31, 0, 0, 0, 8'h00, 1, 0, 2'd0, 4'd2, 1);
        add("co idle", 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 2'd0, 4'd2, 0);
        // start of a 5-byte frame, cut by reset
        add("rs hdr",  1, 8'hA5, 0, 0, 0, 8'h00, 0, 0, 2'd0, 4'd2, 1);
        add("rs len",  1, 8'h05, 0, 0, 0, 8'h00, 0, 0, 2'd0, 4'd5, 1);
        add("rs p0",   1, 8'h01, 0, 1, 0, 8'h01, 0, 0, 2'd0, 4'd5, 1);
        add("rs p1",   1, 8'h02, 0, 1, 1, 8'h02, 0, 0, 2'd0, 4'd5, 1);
        apply_vecs();

        rst_i = 1'b1;
        #1;
        check("mid-frame reset", all_out(), 32'd0);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk_i);
            #1;
            check($sformatf("held reset %0d", k), all_out(), 32'd0);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        check("after reset", all_out(), 32'd0);

        // leading junk ignored, HEADER value taken as payload
        add("hp junk0", 1, 8'h00, 0, 0, 0, 8'h00, 0, 0, 2'd0, 4'd0, 0);
        add("hp junkF", 1, 8'hFF, 0, 0, 0, 8'h00, 0, 0, 2'd0, 4'd0, 0);
        add("hp hdr",   1, 8'hA5, 0, 0, 0, 8'h00, 0, 0, 2'd0, 4'd0, 1);
        add("hp len",   1, 8'h01, 0, 0, 0, 8'h00, 0, 0, 2'd0, 4'd1, 1);
        add("hp p0",    1, 8'hA5, 0, 1, 0, 8'hA5, 0, 0, 2'd0, 4'd1, 1);
        add("hp chk",   1, 8'hA4, 0, 0, 0, 8'h00, 1, 0, 2'd0, 4'd1, 1);
        add("hp idle",  0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 2'd0, 4'd1, 0);
        apply_vecs();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
